lif_param_loader: RTL and testbench

- Serial configuration front-end feeding lif_neuron_system: deserialises frames on serial_data while load_mode is high.
- Checks sync header and checksum, then atomically commits threshold, leak, channel weights and refractory period to the neuron core.
- Drives params_ready. Until the first valid frame, and after any rejected frame, the neuron runs on the last committed or default parameter set.

---
 rtl/lif_param_loader_if.sv | 42 ++++
 rtl/lif_param_loader.sv | 117 +++++++++++
 tb/tb_lif_param_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_param_loader_if.sv
// lif_param_loader_if
//   Configuration bus between a serial frame source and lif_param_loader.
//   master : drives enable, load_mode, serial_data; observes the active
//            parameter set and the status flags.
//   slave  : the loader itself (the inverse directions).
//   Signals:
//     enable        - global advance qualifier
//     load_mode     - frame gate, high while a frame is being sent
//     serial_data   - frame bit, MSB-first
//     threshold     - active threshold (8)
//     leak_rate     - active leak rate (8)
//     weight_a      - active channel A weight (8)
//     weight_b      - active channel B weight (8)
//     refrac_period - active refractory period (4)
//     params_ready  - active set is stable
//     load_done     - one-cycle commit pulse
//     load_err      - sticky frame error
interface lif_param_loader_if;
    logic       enable;
    logic       load_mode;
    logic       serial_data;
    logic [7:0] threshold;
    logic [7:0] leak_rate;
    logic [7:0] weight_a;
    logic [7:0] weight_b;
    logic [3:0] refrac_period;
    logic       params_ready;
    logic       load_done;
    logic       load_err;

    modport master (
        output enable, load_mode, serial_data,
        input  threshold, leak_rate, weight_a, weight_b, refrac_period,
        input  params_ready, load_done, load_err
    );

    modport slave (
        input  enable, load_mode, serial_data,
        output threshold, leak_rate, weight_a, weight_b, refrac_period,
        output params_ready, load_done, load_err
    );
endinterface

// File: rtl/lif_param_loader.sv
// lif_param_loader
//   Serial configuration front-end for lif_neuron_system. A 44-bit frame
//   (hdr, threshold, leak, weight_a, weight_b, refrac, chk; MSB-first) is
//   shifted into a shadow register while load_mode is high. The header and
//   the nibble-XOR checksum are then checked and, if both are good, all five
//   fields are committed to the active registers on a single edge.
//   Ports:
//     clk   - clock
//     reset - synchronous, active-high reset
//     bus   - lif_param_loader_if.slave (enable, load_mode, serial_data in;
//             active parameter set, params_ready, load_done, load_err out)
module lif_param_loader #(
    parameter logic [7:0] DEF_THRESHOLD = 8'd100,
    parameter logic [7:0] DEF_LEAK      = 8'd4,
    parameter logic [7:0] DEF_WEIGHT_A  = 8'd8,
    parameter logic [7:0] DEF_WEIGHT_B  = 8'd8,
    parameter logic [3:0] DEF_REFRAC    = 4'd2,
    parameter logic [3:0] SYNC_HDR      = 4'b1010
) (
    input  logic                 clk,
    input  logic                 reset,
    lif_param_loader_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        DONE
    } state_t;

    state_t      state;
    logic [43:0] shadow;
    logic [5:0]  bit_cnt;
    logic [3:0]  chk_calc;
    logic        frame_ok;

    // XOR of the nine payload nibbles (bits 39..4 of the shadow register).
    always_comb begin
        chk_calc = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            chk_calc = chk_calc ^ shadow[39 - 4*i -: 4];
        end
        frame_ok = (shadow[43:40] == SYNC_HDR) && (shadow[3:0] == chk_calc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            shadow            <= '0;
            bit_cnt           <= '0;
            bus.threshold     <= DEF_THRESHOLD;
            bus.leak_rate     <= DEF_LEAK;
            bus.weight_a      <= DEF_WEIGHT_A;
            bus.weight_b      <= DEF_WEIGHT_B;
            bus.refrac_period <= DEF_REFRAC;
            bus.params_ready  <= 1'b1;
            bus.load_done     <= 1'b0;
            bus.load_err      <= 1'b0;
        end else if (bus.enable) begin
            bus.load_done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (bus.load_mode) begin
                        shadow           <= 44'(bus.serial_data);
                        bit_cnt          <= 6'd1;
                        bus.load_err     <= 1'b0;
                        bus.params_ready <= 1'b0;
                        state            <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.load_mode) begin
                        shadow  <= {shadow[42:0], bus.serial_data};
                        bit_cnt <= bit_cnt + 6'd1;
                        // bit_cnt==43 means this edge samples bit 43.
                        if (bit_cnt == 6'd43) begin
                            state <= CHECK;
                        end
                    end else begin
                        shadow           <= '0;
                        bit_cnt          <= '0;
                        bus.load_err     <= 1'b1;
                        bus.params_ready <= 1'b1;
                        state            <= IDLE;
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        bus.threshold     <= shadow[39:32];
                        bus.leak_rate     <= shadow[31:24];
                        bus.weight_a      <= shadow[23:16];
                        bus.weight_b      <= shadow[15:8];
                        bus.refrac_period <= shadow[7:4];
                        bus.load_done     <= 1'b1;
                    end else begin
                        bus.load_err      <= 1'b1;
                    end
                    bus.params_ready <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    // Counter stays saturated until the frame gate drops.
                    if (!bus.load_mode) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_param_loader.sv
module tb_lif_param_loader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lif_param_loader_if bus ();

    lif_param_loader #(
        .DEF_THRESHOLD (8'd100),
        .DEF_LEAK      (8'd4),
        .DEF_WEIGHT_A  (8'd8),
        .DEF_WEIGHT_B  (8'd8),
        .DEF_REFRAC    (4'd2),
        .SYNC_HDR      (4'b1010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] thr;
        logic [7:0] leak;
        logic [7:0] wa;
        logic [7:0] wb;
        logic [3:0] rf;
    } params_t;

    typedef struct {
        logic    commit;
        params_t p;
        int      low;
    } event_t;

    event_t  exp_q[$];
    params_t cur;
    int      total = 0;
    int      bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic params_t defaults();
        params_t p;
        p.thr = 8'd100; p.leak = 8'd4; p.wa = 8'd8; p.wb = 8'd8; p.rf = 4'd2;
        return p;
    endfunction

    function automatic logic [3:0] nib_xor(input logic [35:0] payload);
        logic [3:0] x = 4'h0;
        for (int i = 0; i < 9; i++) x = x ^ payload[4*i +: 4];
        return x;
    endfunction

    function automatic logic [43:0] mk_frame(input logic [3:0] hdr, input params_t p);
        logic [35:0] payload = {p.thr, p.leak, p.wa, p.wb, p.rf};
        return {hdr, payload, nib_xor(payload)};
    endfunction

    // Reference model: what the loader must report for a frame of nbits bits.
    task automatic push_expect(input logic [43:0] f, input int nbits, input int stall);
        event_t e;
        logic [35:0] payload = f[39:4];
        e.low = nbits + stall;
        if (nbits == 44 && f[43:40] == 4'b1010 && f[3:0] == nib_xor(payload)) begin
            cur.thr = payload[35:28]; cur.leak = payload[27:20];
            cur.wa  = payload[19:12]; cur.wb   = payload[11:4];
            cur.rf  = payload[3:0];
            e.commit = 1'b1;
        end else begin
            e.commit = 1'b0;
        end
        e.p = cur;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic lm, input logic sd, input logic en);
        bus.load_mode   = lm;
        bus.serial_data = sd;
        bus.enable      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [43:0] f, input int nbits,
                              input int stall_at, input int stall_len, input int extra);
        logic err_before = bus.load_err;
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) repeat (stall_len) cyc(1'b1, f[43-i], 1'b0);
            cyc(1'b1, f[43-i], 1'b1);
            if (i == 0 && err_before) check("err_clear", bus.load_err, 0);
        end
        if (nbits == 44) repeat (1 + extra) cyc(1'b1, 1'($urandom), 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_thr"},   bus.threshold,     100);
        check({tag, "_leak"},  bus.leak_rate,     4);
        check({tag, "_wa"},    bus.weight_a,      8);
        check({tag, "_wb"},    bus.weight_b,      8);
        check({tag, "_rf"},    bus.refrac_period, 2);
        check({tag, "_ready"}, bus.params_ready,  1);
        check({tag, "_err"},   bus.load_err,      0);
        check({tag, "_done"},  bus.load_done,     0);
    endtask

    // Monitor: every rising edge of params_ready closes one frame.
    logic prev_ready = 1'b1;
    logic prev_done  = 1'b0;
    int   low_cnt    = 0;

    always @(negedge clk) begin
        logic rise;
        event_t e;
        if (reset) begin
            prev_ready = 1'b1;
            prev_done  = 1'b0;
            low_cnt    = 0;
        end else begin
            rise = bus.params_ready && !prev_ready;
            if (rise) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_end", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_flag",  bus.load_done,     e.commit);
                    check("err_flag",   bus.load_err,      !e.commit);
                    check("thr",        bus.threshold,     e.p.thr);
                    check("leak",       bus.leak_rate,     e.p.leak);
                    check("weight_a",   bus.weight_a,      e.p.wa);
                    check("weight_b",   bus.weight_b,      e.p.wb);
                    check("refrac",     bus.refrac_period, e.p.rf);
                    check("ready_low",  low_cnt,           e.low);
                end
                low_cnt = 0;
            end else begin
                check("spurious_done", bus.load_done, 0);
            end
            if (!bus.params_ready) low_cnt++;
            prev_ready = bus.params_ready;
            prev_done  = bus.load_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        params_t    pa;
        logic [43:0] f;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.load_mode   = 1'b0;
        bus.serial_data = 1'b0;
        cur             = defaults();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
        check_defaults("reset");

        // Frame A
        pa.thr = 8'h50; pa.leak = 8'h03; pa.wa = 8'h12; pa.wb = 8'h21; pa.rf = 4'h4;
        f = mk_frame(4'b1010, pa);
        push_expect(f, 44, 0);
        send_frame(f, 44, -1, 0, 0);

        // Bad checksum, then bad header
        f[3:0] = 4'h3;
        push_expect(f, 44, 0);
        send_frame(f, 44, -1, 0, 0);
        f = mk_frame(4'b1011, pa);
        push_expect(f, 44, 0);
        send_frame(f, 44, -1, 0, 0);

        // Abort after 20 bits, then a good frame
        pa.thr = 8'h77; pa.leak = 8'h01; pa.wa = 8'hF0; pa.wb = 8'h0F; pa.rf = 4'h9;
        f = mk_frame(4'b1010, pa);
        push_expect(f, 20, 0);
        send_frame(f, 20, -1, 0, 0);
        push_expect(f, 44, 0);
        send_frame(f, 44, -1, 0, 0);

        // Reset at bit 30, load_mode held high into a new frame
        for (int i = 0; i < 30; i++) cyc(1'b1, f[43-i], 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur = defaults();
        check_defaults("midreset");
        pa.thr = 8'hC3; pa.leak = 8'h22; pa.wa = 8'h05; pa.wb = 8'hA0; pa.rf = 4'hE;
        f = mk_frame(4'b1010, pa);
        push_expect(f, 44, 0);
        send_frame(f, 44, -1, 0, 0);

        // 60 cycles high: valid frame plus 16 extra bits
        pa.thr = 8'h11; pa.leak = 8'h99;
        f = mk_frame(4'b1010, pa);
        push_expect(f, 44, 0);
        send_frame(f, 44, -1, 0, 15);

        // enable low for 5 cycles mid-frame
        pa.wa = 8'h3C; pa.rf = 4'h1;
        f = mk_frame(4'b1010, pa);
        push_expect(f, 44, 5);
        send_frame(f, 44, 20, 5, 0);

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            int kind, nbits, st_at, st_len, extra;
            logic [3:0] hdr;
            pa.thr = 8'($urandom); pa.leak = 8'($urandom);
            pa.wa  = 8'($urandom); pa.wb   = 8'($urandom);
            pa.rf  = 4'($urandom);
            kind   = $urandom_range(0, 5);
            hdr    = 4'b1010;
            if (kind == 1) hdr = 4'($urandom_range(0, 15)) ^ 4'b0001;
            f = mk_frame(hdr, pa);
            if (kind == 0) f[3:0] = f[3:0] ^ 4'($urandom_range(1, 15));
            nbits  = (kind == 2) ? $urandom_range(1, 43) : 44;
            st_at  = (kind == 3) ? $urandom_range(1, 43) : -1;
            st_len = (kind == 3) ? $urandom_range(1, 6) : 0;
            extra  = $urandom_range(0, 3);
            push_expect(f, nbits, (st_at >= 0 && st_at < nbits) ? st_len : 0);
            send_frame(f, nbits, st_at, st_len, extra);
        end

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
